// File: rtl/system_top_arith_pkg.sv
// Shared arithmetic helpers for the synchronisation datapath cores:
// product width, saturation bounds and the rounding constant.
package system_top_arith_pkg;

   // Widest intermediate any core may request from these helpers.
   localparam int ARITH_MAX_W = 128;

   typedef logic signed [ARITH_MAX_W-1:0] arith_t;

   function automatic int prod_width(input int a_w, input int b_w);
      return a_w + b_w + 1;
   endfunction

   function automatic arith_t sat_max(input int w);
      arith_t one;
      one = arith_t'(1);
      return (one <<< (w - 1)) - one;
   endfunction

   function automatic arith_t sat_min(input int w);
      arith_t one;
      one = arith_t'(1);
      return -(one <<< (w - 1));
   endfunction

   // Half an output LSB when rounding is enabled; a plain shift otherwise.
   function automatic arith_t round_const(input int shift, input int rnd);
      arith_t one;
      one = arith_t'(1);
      if (rnd != 0 && shift > 0) begin
         return one <<< (shift - 1);
      end
      return '0;
   endfunction

endpackage

// File: rtl/system_top_mul_rsat.sv
// Combinational round / arithmetic-shift / saturate stage with range flag.
// Shared by the multiplier, adder and accumulator cores.
module system_top_mul_rsat
   import system_top_arith_pkg::*;
#(
   parameter int IN_WIDTH   = 61,
   parameter int DOUT_WIDTH = 48,
   parameter int SHIFT      = 0,
   parameter int ROUND      = 0,
   parameter int SAT        = 1
) (
   input  logic signed [IN_WIDTH-1:0]   p_i,
   output logic        [DOUT_WIDTH-1:0] dout_o,
   output logic                         ovf_o
);

   // One guard bit so adding the rounding constant can never wrap.
   localparam int EXT_W = IN_WIDTH + 1;

   localparam logic signed [EXT_W-1:0] RND_C = EXT_W'(round_const(SHIFT, ROUND));
   localparam logic signed [EXT_W-1:0] Q_MAX = EXT_W'(sat_max(DOUT_WIDTH));
   localparam logic signed [EXT_W-1:0] Q_MIN = EXT_W'(sat_min(DOUT_WIDTH));

   logic signed [EXT_W-1:0] sum;
   logic signed [EXT_W-1:0] q;
   logic                    above;
   logic                    below;

   always_comb begin
      // NOTE: every output gets a value before any branch, so no latch can be inferred.
      dout_o = '0;
      sum    = {p_i[IN_WIDTH-1], p_i} + RND_C;
      q      = sum >>> SHIFT;
      above  = (q > Q_MAX);
      below  = (q < Q_MIN);
      ovf_o  = above | below;
      dout_o = q[DOUT_WIDTH-1:0];
      if (SAT != 0) begin
         if (above) begin
            dout_o = Q_MAX[DOUT_WIDTH-1:0];
         end else if (below) begin
            dout_o = Q_MIN[DOUT_WIDTH-1:0];
         end
      end
   end

endmodule

// File: rtl/system_top_mul_pipe_sat.sv
// Pipelined signed multiplier with rounding shift, saturation and a
// valid/ready handshake driven by one global advance enable.
module system_top_mul_pipe_sat
   import system_top_arith_pkg::*;
#(
   parameter int DIN0_WIDTH  = 32,
   parameter int DIN1_WIDTH  = 28,
   parameter int DOUT_WIDTH  = 48,
   parameter int DIN1_SIGNED = 0,
   parameter int NUM_STAGE   = 3,
   parameter int SHIFT       = 0,
   parameter int ROUND       = 0,
   parameter int SAT         = 1
) (
   input  logic                  ap_clk,
   input  logic                  ap_rst_n,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [DIN0_WIDTH-1:0] din0,
   input  logic [DIN1_WIDTH-1:0] din1,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [DOUT_WIDTH-1:0] dout,
   output logic                  ovf
);

   localparam int PW = prod_width(DIN0_WIDTH, DIN1_WIDTH);

   // Full-precision product; din1 is widened by one bit, signed or zero-filled.
   function automatic logic signed [PW-1:0] mul(input logic [DIN0_WIDTH-1:0] a,
                                                input logic [DIN1_WIDTH-1:0] b);
      logic signed [PW-1:0] a_x;
      logic signed [PW-1:0] b_x;
      logic                 b_msb;
      b_msb = (DIN1_SIGNED != 0) ? b[DIN1_WIDTH-1] : 1'b0;
      a_x   = {{(PW-DIN0_WIDTH){a[DIN0_WIDTH-1]}}, a};
      b_x   = {{(PW-DIN1_WIDTH){b_msb}}, b};
      return a_x * b_x;
   endfunction

   logic                    adv;
   logic [NUM_STAGE-1:0]    vld_q;
   logic [NUM_STAGE-1:0]    vld_d;
   logic signed [PW-1:0]    rsat_p;
   logic [DOUT_WIDTH-1:0]   dout_q;
   logic [DOUT_WIDTH-1:0]   dout_d;
   logic                    ovf_q;
   logic                    ovf_d;

   // Bubbles are kept: the whole pipe moves together or holds together.
   assign adv       = ~vld_q[NUM_STAGE-1] | out_ready;
   assign in_ready  = adv;
   assign out_valid = vld_q[NUM_STAGE-1];
   assign dout      = dout_q;
   assign ovf       = ovf_q;
   assign vld_d     = NUM_STAGE'({vld_q, in_valid});

   // NOTE: non-blocking assignments, so every stage samples its pre-edge neighbour.
   always_ff @(posedge ap_clk or negedge ap_rst_n) begin
      if (!ap_rst_n) begin
         vld_q <= '0;
      end else if (adv) begin
         vld_q <= vld_d;
      end
   end

   generate
      if (NUM_STAGE == 1) begin : g_comb
         assign rsat_p = mul(din0, din1);
      end else begin : g_ops
         logic [DIN0_WIDTH-1:0] a_q;
         logic [DIN1_WIDTH-1:0] b_q;

         // NOTE: data stages are reset too, so no X ever reaches dout after a mid-stream reset.
         always_ff @(posedge ap_clk or negedge ap_rst_n) begin
            if (!ap_rst_n) begin
               a_q <= '0;
               b_q <= '0;
            end else if (adv) begin
               a_q <= din0;
               b_q <= din1;
            end
         end

         if (NUM_STAGE == 2) begin : g_mul_final
            assign rsat_p = mul(a_q, b_q);
         end else begin : g_mul_reg
            logic signed [PW-1:0] prod_q [NUM_STAGE-2];

            always_ff @(posedge ap_clk or negedge ap_rst_n) begin
               if (!ap_rst_n) begin
                  for (int i = 0; i < NUM_STAGE - 2; i++) begin
                     prod_q[i] <= '0;
                  end
               end else if (adv) begin
                  prod_q[0] <= mul(a_q, b_q);
                  for (int i = 1; i < NUM_STAGE - 2; i++) begin
                     prod_q[i] <= prod_q[i-1];
                  end
               end
            end

            assign rsat_p = prod_q[NUM_STAGE-3];
         end
      end
   endgenerate

   system_top_mul_rsat #(
      .IN_WIDTH   (PW),
      .DOUT_WIDTH (DOUT_WIDTH),
      .SHIFT      (SHIFT),
      .ROUND      (ROUND),
      .SAT        (SAT)
   ) u_rsat (
      .p_i    (rsat_p),
      .dout_o (dout_d),
      .ovf_o  (ovf_d)
   );

   always_ff @(posedge ap_clk or negedge ap_rst_n) begin
      if (!ap_rst_n) begin
         dout_q <= '0;
         ovf_q  <= 1'b0;
      end else if (adv) begin
         dout_q <= dout_d;
         ovf_q  <= ovf_d;
      end
   end

endmodule

// File: tb/tb_system_top_mul_pipe_sat.sv
// Bench for system_top_mul_pipe_sat: five parameter sets share one stimulus
// stream; a per-instance scoreboard compares every emitted beat to a model.
module tb_system_top_mul_pipe_sat;

   localparam int NDUT = 5;
   localparam int DW   = 48;

   typedef struct {
      int ns;
      int sh;
      int rnd;
      int sat;
      int sgn;
   } cfg_t;

   typedef struct {
      int          dut;
      logic [31:0] a;
      logic [27:0] b;
      logic [47:0] d;
      logic        o;
   } vec_t;

   logic                       clk;
   logic                       rst_n;
   logic                       in_valid;
   logic                       out_ready;
   logic [31:0]                din0;
   logic [27:0]                din1;
   logic [NDUT-1:0]            in_ready_s;
   logic [NDUT-1:0]            out_valid_s;
   logic [NDUT-1:0]            ovf_s;
   logic [NDUT-1:0][DW-1:0]    dout_s;

   int n_checks = 0;
   int n_fail   = 0;

   system_top_mul_pipe_sat u_dut0 (
      .ap_clk(clk), .ap_rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_s[0]),
      .din0(din0), .din1(din1), .out_valid(out_valid_s[0]), .out_ready(out_ready),
      .dout(dout_s[0]), .ovf(ovf_s[0]));

   system_top_mul_pipe_sat #(.NUM_STAGE(1), .SAT(0)) u_dut1 (
      .ap_clk(clk), .ap_rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_s[1]),
      .din0(din0), .din1(din1), .out_valid(out_valid_s[1]), .out_ready(out_ready),
      .dout(dout_s[1]), .ovf(ovf_s[1]));

   system_top_mul_pipe_sat #(.NUM_STAGE(4), .DIN1_SIGNED(1), .SAT(1)) u_dut2 (
      .ap_clk(clk), .ap_rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_s[2]),
      .din0(din0), .din1(din1), .out_valid(out_valid_s[2]), .out_ready(out_ready),
      .dout(dout_s[2]), .ovf(ovf_s[2]));

   system_top_mul_pipe_sat #(.NUM_STAGE(3), .SHIFT(4), .ROUND(1), .SAT(1)) u_dut3 (
      .ap_clk(clk), .ap_rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_s[3]),
      .din0(din0), .din1(din1), .out_valid(out_valid_s[3]), .out_ready(out_ready),
      .dout(dout_s[3]), .ovf(ovf_s[3]));

   system_top_mul_pipe_sat #(.NUM_STAGE(2), .SHIFT(4), .ROUND(0), .SAT(0), .DIN1_SIGNED(1)) u_dut4 (
      .ap_clk(clk), .ap_rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_s[4]),
      .din0(din0), .din1(din1), .out_valid(out_valid_s[4]), .out_ready(out_ready),
      .dout(dout_s[4]), .ovf(ovf_s[4]));

   function automatic cfg_t get_cfg(input int i);
      cfg_t c;
      case (i)
         0:       c = '{ns: 3, sh: 0, rnd: 0, sat: 1, sgn: 0};
         1:       c = '{ns: 1, sh: 0, rnd: 0, sat: 0, sgn: 0};
         2:       c = '{ns: 4, sh: 0, rnd: 0, sat: 1, sgn: 1};
         3:       c = '{ns: 3, sh: 4, rnd: 1, sat: 1, sgn: 0};
         default: c = '{ns: 2, sh: 4, rnd: 0, sat: 0, sgn: 1};
      endcase
      return c;
   endfunction

   // Reference: exact integer product, rounding add, floor shift, range clamp.
   function automatic logic [48:0] model(input int i, input logic [31:0] a, input logic [27:0] b);
      cfg_t   c;
      longint pa, pb, p, r, q, lim, v;
      logic   o;
      c   = get_cfg(i);
      pa  = longint'(signed'(a));
      pb  = (c.sgn != 0) ? longint'(signed'(b)) : longint'({36'd0, b});
      p   = pa * pb;
      r   = (c.rnd != 0 && c.sh > 0) ? (64'sd1 <<< (c.sh - 1)) : 64'sd0;
      q   = (p + r) >>> c.sh;
      lim = 64'sd1 <<< (DW - 1);
      o   = (q > lim - 1) || (q < -lim);
      v   = q;
      if (c.sat != 0) begin
         if (q > lim - 1) v = lim - 1;
         else if (q < -lim) v = -lim;
      end
      return {o, v[47:0]};
   endfunction

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Scoreboard monitor, sampled on the falling edge.
   logic [48:0] sb [NDUT][$];
   bit          stall_q [NDUT];
   logic [48:0] held [NDUT];
   int          emitted [NDUT];

   initial begin
      for (int i = 0; i < NDUT; i++) begin
         emitted[i] = 0;
         stall_q[i] = 1'b0;
         held[i]    = '0;
      end
   end

   always @(negedge clk) begin
      for (int i = 0; i < NDUT; i++) begin
         if (!rst_n) begin
            sb[i].delete();
            stall_q[i] = 1'b0;
         end else begin
            if (stall_q[i]) begin
               check($sformatf("dut%0d_stall_valid", i), out_valid_s[i], 1);
               check($sformatf("dut%0d_stall_hold", i), {ovf_s[i], dout_s[i]}, held[i]);
            end
            if (out_valid_s[i] && out_ready) begin
               check($sformatf("dut%0d_beat_expected", i), sb[i].size() != 0, 1);
               if (sb[i].size() != 0) begin
                  logic [48:0] e;
                  e = sb[i].pop_front();
                  check($sformatf("dut%0d_sb_dout", i), dout_s[i], e[47:0]);
                  check($sformatf("dut%0d_sb_ovf", i), ovf_s[i], e[48]);
               end
               emitted[i]++;
            end
            if (in_valid && in_ready_s[i]) begin
               sb[i].push_back(model(i, din0, din1));
            end
            stall_q[i] = out_valid_s[i] && !out_ready;
            held[i]    = {ovf_s[i], dout_s[i]};
            if (stall_q[i]) begin
               check($sformatf("dut%0d_stall_in_ready", i), in_ready_s[i], 0);
            end
         end
      end
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   vec_t        vecs[11];
   logic [31:0] bp_a[8];
   logic [27:0] bp_b[8];
   int          lat;
   int          base;
   int          k;
   int          lat_r[NDUT];
   int          ghost[NDUT];

   initial begin
      vecs[0]  = '{dut: 0, a: 32'hFFFF_FFFD, b: 28'd5,         d: 48'hFFFF_FFFF_FFF1, o: 1'b0};
      vecs[1]  = '{dut: 0, a: 32'h7FFF_FFFF, b: 28'hFFF_FFFF,  d: 48'h7FFF_FFFF_FFFF, o: 1'b1};
      vecs[2]  = '{dut: 1, a: 32'h7FFF_FFFF, b: 28'hFFF_FFFF,  d: 48'hFFFF_7000_0001, o: 1'b1};
      vecs[3]  = '{dut: 0, a: 32'h8000_0000, b: 28'hFFF_FFFF,  d: 48'h8000_0000_0000, o: 1'b1};
      vecs[4]  = '{dut: 2, a: 32'h8000_0000, b: 28'hFFF_FFFF,  d: 48'h0000_8000_0000, o: 1'b0};
      vecs[5]  = '{dut: 3, a: 32'd25,        b: 28'd1,         d: 48'd2,              o: 1'b0};
      vecs[6]  = '{dut: 3, a: 32'hFFFF_FFE8, b: 28'd1,         d: 48'hFFFF_FFFF_FFFF, o: 1'b0};
      vecs[7]  = '{dut: 3, a: 32'd24,        b: 28'd1,         d: 48'd2,              o: 1'b0};
      vecs[8]  = '{dut: 4, a: 32'd25,        b: 28'd1,         d: 48'd1,              o: 1'b0};
      vecs[9]  = '{dut: 1, a: 32'hFFFF_FFFD, b: 28'd5,         d: 48'hFFFF_FFFF_FFF1, o: 1'b0};
      vecs[10] = '{dut: 4, a: 32'h7FFF_FFFF, b: 28'h7FF_FFFF,  d: 48'hFFFF_F780_0000, o: 1'b1};

      rst_n     = 1'b0;
      in_valid  = 1'b0;
      out_ready = 1'b1;
      din0      = '0;
      din1      = '0;
      #1;
      for (int i = 0; i < NDUT; i++) begin
         check($sformatf("dut%0d_reset_valid", i), out_valid_s[i], 0);
         check($sformatf("dut%0d_reset_dout", i), {ovf_s[i], dout_s[i]}, 0);
      end
      #11 rst_n = 1'b1;
      #1;
      for (int i = 0; i < NDUT; i++) check($sformatf("dut%0d_reset_in_ready", i), in_ready_s[i], 1);
      tick();

      // Directed vectors: latency, value and overflow flag.
      for (int j = 0; j < 11; j++) begin
         in_valid = 1'b1;
         din0     = vecs[j].a;
         din1     = vecs[j].b;
         tick();
         in_valid = 1'b0;
         lat      = 1;
         while (!out_valid_s[vecs[j].dut] && lat < 20) begin
            tick();
            lat++;
         end
         check($sformatf("vec%0d_latency", j), lat, get_cfg(vecs[j].dut).ns);
         check($sformatf("vec%0d_dout", j), dout_s[vecs[j].dut], vecs[j].d);
         check($sformatf("vec%0d_ovf", j), ovf_s[vecs[j].dut], vecs[j].o);
         repeat (6) tick();
      end

      // 16-beat back-to-back ramp must drain at one beat per cycle.
      base = emitted[0];
      for (int j = 0; j < 16; j++) begin
         in_valid = 1'b1;
         din0     = 32'(j) - 32'd8;
         din1     = 28'd3;
         tick();
      end
      in_valid = 1'b0;
      repeat (2) tick();
      @(negedge clk);
      #1;
      check("ramp_throughput", emitted[0] - base, 16);
      repeat (6) tick();

      // Backpressure: 8 beats, out_ready low for 5 cycles mid-stream.
      for (int j = 0; j < 8; j++) begin
         bp_a[j] = $urandom;
         bp_b[j] = 28'($urandom);
      end
      base = emitted[0];
      k    = 0;
      for (int c = 0; c < 40 && k < 8; c++) begin
         out_ready = !(c >= 3 && c < 8);
         in_valid  = 1'b1;
         din0      = bp_a[k];
         din1      = bp_b[k];
         #1;
         if (c >= 3 && c < 8) check($sformatf("bp_in_ready_c%0d", c), in_ready_s[0], 0);
         if (in_ready_s[0]) k++;
         tick();
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      check("bp_all_sent", k, 8);
      repeat (8) tick();
      check("bp_all_received", emitted[0] - base, 8);

      // Randomized traffic with random backpressure and extreme operands.
      for (int c = 0; c < 300; c++) begin
         int r;
         in_valid  = ($urandom_range(3) != 0);
         out_ready = ($urandom_range(9) < 7);
         r         = $urandom_range(3);
         din0      = (r == 0) ? 32'h7FFF_FFFF : (r == 1) ? 32'h8000_0000 : $urandom;
         din1      = ($urandom_range(3) == 0) ? 28'hFFF_FFFF : 28'($urandom);
         tick();
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      repeat (8) tick();

      // Reset with three beats in flight, then one fresh beat.
      for (int j = 0; j < 3; j++) begin
         in_valid = 1'b1;
         din0     = 32'(100 + j);
         din1     = 28'd7;
         tick();
      end
      in_valid = 1'b0;
      rst_n    = 1'b0;
      #1;
      for (int i = 0; i < NDUT; i++) begin
         check($sformatf("dut%0d_midrst_valid", i), out_valid_s[i], 0);
         check($sformatf("dut%0d_midrst_dout", i), {ovf_s[i], dout_s[i]}, 0);
      end
      tick();
      rst_n = 1'b1;
      for (int i = 0; i < NDUT; i++) ghost[i] = 0;
      for (int c = 0; c < 6; c++) begin
         tick();
         for (int i = 0; i < NDUT; i++) if (out_valid_s[i]) ghost[i]++;
      end
      for (int i = 0; i < NDUT; i++) check($sformatf("dut%0d_no_ghost", i), ghost[i], 0);

      in_valid = 1'b1;
      din0     = 32'hFFFF_FF00;
      din1     = 28'd9;
      tick();
      in_valid = 1'b0;
      for (int i = 0; i < NDUT; i++) lat_r[i] = 0;
      for (int c = 1; c <= 8; c++) begin
         for (int i = 0; i < NDUT; i++) if (lat_r[i] == 0 && out_valid_s[i]) lat_r[i] = c;
         tick();
      end
      for (int i = 0; i < NDUT; i++) check($sformatf("dut%0d_post_rst_latency", i), lat_r[i], get_cfg(i).ns);

      repeat (4) tick();
      for (int i = 0; i < NDUT; i++) check($sformatf("dut%0d_sb_drained", i), sb[i].size(), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/system_top_mul_pipe_sat.md
# system_top_mul_pipe_sat

Pipelined, parametrised multiplier for the synchronisation datapath. It multiplies a signed operand by a signed or zero-extended second operand, and optionally applies a rounding right-shift and saturation to the output width. It moves data with a valid/ready handshake and stalls cleanly under backpressure. It replaces the fixed-width, zero-latency multiplier cores wherever the correlator and CFO-estimation stages need registered, width-reduced products.

## Interface
- `DIN0_WIDTH`, default 32: width of `din0`; always signed.
- `DIN1_WIDTH`, default 28: width of `din1`.
- `DOUT_WIDTH`, default 48: result width; must be ≤ `DIN0_WIDTH`+`DIN1_WIDTH`+1.
- `DIN1_SIGNED`, default 0:
  - 0: `din1` is zero-extended by one bit (unsigned).
  - 1: `din1` is two's complement.
- `NUM_STAGE`, default 3: pipeline depth in cycles; legal range 1..4.
- `SHIFT`, default 0: arithmetic right shift applied to the full product; range 0..`DIN0_WIDTH`+`DIN1_WIDTH`-1.
- `ROUND`, default 0: 1 adds 2^(`SHIFT`-1) before the shift (round half up); ignored when `SHIFT`=0.
- `SAT`, default 1:
  - 1: clamp to the `DOUT_WIDTH` signed range.
  - 0: truncate (wrap).
- `ap_clk` in 1: clock, rising edge.
- `ap_rst_n` in 1: asynchronous active-low reset.
- `in_valid` in 1: input beat valid.
- `in_ready` out 1: block accepts a beat this cycle.
- `din0` in `DIN0_WIDTH`: operand A.
- `din1` in `DIN1_WIDTH`: operand B.
- `out_valid` out 1: `dout`/`ovf` valid.
- `out_ready` in 1: downstream accepts.
- `dout` out `DOUT_WIDTH`: result.
- `ovf` out 1: the shifted product was outside the `DOUT_WIDTH` signed range; asserted whether `SAT` is 0 or 1.

## Operation
- Full product P = signed(`din0`) × B, with width `DIN0_WIDTH`+`DIN1_WIDTH`+1.
  - B = {1'b0,`din1`} when `DIN1_SIGNED`=0, otherwise sign-extended `din1`.
- Q = (P + R) >>> `SHIFT`, where R = 2^(`SHIFT`-1) if `ROUND`=1 and `SHIFT`>0, else 0.
  - The addition is done one bit wider than P so it cannot wrap.
- Range check: `ovf` = Q > 2^(`DOUT_WIDTH`-1)-1 or Q < -2^(`DOUT_WIDTH`-1).
- Output value:
  - `SAT`=1: `dout` = the clamped value (max positive or most negative on overflow).
  - `SAT`=0: `dout` = Q[`DOUT_WIDTH`-1:0].
- Pipeline model: a single global advance signal, `adv` = !`out_valid` | `out_ready`.
  - All stage registers and stage valid bits shift only when `adv`=1.
  - `in_ready` = `adv`.
  - A beat is accepted when `in_valid` & `in_ready`.
- Stage placement:
  - Stage 1 registers the operands.
  - The product is registered at stage 2 (when `NUM_STAGE`≥2).
  - Shift/round/saturate is registered at the final stage.
  - Any extra stages (`NUM_STAGE`=4) sit between the product and the round stage.
  - `NUM_STAGE`=1 computes everything combinationally into the single output register.
- Bubbles are not collapsed. Beat order is preserved and no beat is dropped or duplicated.

## Timing
- Reset (asynchronous, immediate):
  - All stage valid bits, `out_valid`, `dout` and `ovf` go to 0.
  - `in_ready` reads 1 once `ap_rst_n` is high, since the pipe is empty.
  - A reset mid-stream discards in-flight beats.
- Latency: a beat accepted on edge k appears with `out_valid`=1 after edge k+`NUM_STAGE-1`. In other words, it is visible `NUM_STAGE` cycles after `in_valid` is presented, with no stall.
- Throughput: 1 beat/cycle while `out_ready`=1.
- Stall: while `out_valid`=1 and `out_ready`=0:
  - `in_ready`=0.
  - `dout`/`ovf` hold stable.
  - All stages hold.
- Simultaneous accept and emit in the same cycle is legal and required.
- `out_ready` may be asserted while `out_valid`=0; it has no effect.

## Structure
- Shared package `system_top_arith_pkg`:
  - saturation bound constants as functions of width;
  - the rounding constant helper;
  - the product-width function.
- Sub-module `system_top_mul_rsat`: purely combinational shift/round/saturate with `ovf`. It is reused by the adder/accumulator cores.
- The top level holds the stage registers, valid bits and the `adv` logic.

## Test plan
- Defaults, streaming: `din0`=-3, `din1`=5 → `dout`=-15, `ovf`=0, 3 cycles later. A 16-beat back-to-back ramp comes out at 1 beat/cycle, in order.
- Positive saturation: `din0`=0x7FFFFFFF, `din1`=0xFFFFFFF → `dout`=0x7FFF_FFFF_FFFF, `ovf`=1. With `SAT`=0, `dout` = low 48 bits of the product and `ovf`=1.
- Negative saturation: `din0`=0x80000000, `din1`=0xFFFFFFF → `dout`=0x8000_0000_0000, `ovf`=1. With `DIN1_SIGNED`=1 and `din1`=0xFFFFFFF (-1) → `dout`=+2^31, `ovf`=0.
- Rounding, with `SHIFT`=4 and `ROUND`=1:
  - 25×1 → 2;
  - -24×1 → -1;
  - 24×1 → 2;
  - with `ROUND`=0, 25×1 → 1.
- Backpressure: send 8 beats and hold `out_ready`=0 for 5 cycles mid-stream → `in_ready`=0 and `dout` stable throughout. All 8 results arrive in order with no loss or duplication.
- Reset mid-stream: assert `ap_rst_n`=0 with 3 beats in flight → `out_valid` and `dout` go to 0 immediately. After release, none of the old beats appear, and a new beat returns after `NUM_STAGE` cycles. Repeat for `NUM_STAGE`=1 and `NUM_STAGE`=4.
